risc_pipeline_fetch: RTL and testbench
======================================

Name: risc_pipeline_fetch

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage RV32 pipeline.
- Holds PCF and issues instruction fetches over a request/response memory port.
- Delivers InstrD/PCD/PCPlus4D to the decode stage; the decode controller slices opcode/funct3/funct7 from InstrD.
- Handles stall, flush, branch/jump redirect, stale-response discard, and a one-entry hold buffer for responses that arrive while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in InstrD when the IF/ID slot is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- StallF  in  1  hazard unit: do not issue a new fetch.
- StallD  in  1  hazard unit: hold the IF/ID register.
- FlushD  in  1  hazard unit: empty the IF/ID register.
- PCSrcE  in  1  execute stage: taken branch or jump.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= PCF).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- InstrD  out  32  decode-stage instruction.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (async): PCF=RESET_PC, state=S_REQ, hold buffer empty, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, imem_req=0 during reset.
- Memory handshake:
  - A request transfers in any cycle with imem_req&&imem_gnt.
  - req/addr need not be held stable; dropping req before gnt is legal.
  - At most one request outstanding; response arrives ≥1 cycle after grant, in order.
- FSM:
  - S_REQ:
    - imem_req = !StallF && !hold_full && !PCSrcE; imem_addr=PCF.
    - On transfer: inflight_pc<=PCF, PCF<=PCF+4, go S_WAIT.
  - S_WAIT:
    - imem_req=0.
    - On imem_rvalid: deliver (see IF/ID rules), go S_REQ.
    - On PCSrcE without rvalid: go S_DROP.
  - S_DROP:
    - imem_req=0; on imem_rvalid discard data, go S_REQ.
  - imem_rvalid in S_REQ is a protocol error: ignore it, no state change.
- Redirect (PCSrcE=1):
  - PCF<=PCTargetE; overrides the +4 update and StallF.
  - Hold buffer cleared; IF/ID emptied.
  - If it coincides with rvalid in S_WAIT: response discarded, go S_REQ.
- IF/ID update, first match wins:
  1. PCSrcE or FlushD → ValidD<=0, InstrD<=NOP_INSTR, hold buffer cleared.
  2. StallD → IF/ID unchanged; an arriving S_WAIT response is written into the hold buffer (hold_full<=1).
  3. hold_full → IF/ID<=hold contents, ValidD<=1, hold_full<=0. A response cannot arrive in the same cycle, because no request issues while hold_full.
  4. rvalid in S_WAIT → InstrD<=imem_rdata, PCD<=inflight_pc, PCPlus4D<=inflight_pc+4, ValidD<=1.
  5. Otherwise → bubble: ValidD<=0, InstrD<=NOP_INSTR.
- Latency: gnt in cycle n, rvalid in cycle n+1 → ValidD=1 in cycle n+2. Back-to-back throughput is one instruction per 2 cycles with a 1-cycle memory.
- Arithmetic: all PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- StallF and StallD both high with a pending response: response captured in hold buffer, no new request until the buffer drains.
- Reset mid-transaction: outstanding response after reset is ignored (state S_REQ).

Decomposition:
- Package risc_pipeline_pkg:
  - fetch state enum {S_REQ,S_WAIT,S_DROP}.
  - NOP_INSTR constant, RESET_PC default.
  - struct if_id_t {instr, pc, pc_plus4, valid}, also used by the hold buffer.
- One natural sub-module: risc_pipeline_if_id_reg (IF/ID register with stall/flush/load mux). The FSM and PC logic stay in the top.

Test Plan:
- Reset then 1-cycle memory returning 32'h00500093 at addr 0 → req at 0, ValidD=1 cycle 2 with PCD=0, PCPlus4D=4; next req addr 4.
- StallD held 3 cycles as rdata 32'h00208133 arrives → hold_full=1, imem_req=0, IF/ID unchanged; on release InstrD=32'h00208133, then req resumes at next PC.
- PCSrcE=1, PCTargetE=32'h0000_0100 while in S_WAIT (response delayed 3 cycles) → S_DROP, stale rdata discarded, ValidD stays 0, next req addr 0x100.
- PCSrcE coincident with rvalid → response dropped, InstrD=32'h00000013, ValidD=0, next req addr = target.
- FlushD alone with hold_full=1 → hold cleared, ValidD=0, PCF unchanged.
- RESET_PC=32'hFFFF_FFFC → first fetch at 0xFFFFFFFC, PCPlus4D=0, second fetch addr 0.

Source files
------------

// File: rtl/risc_pipeline_pkg.sv
// risc_pipeline_pkg: shared fetch-stage types, constants and slot builder
package risc_pipeline_pkg;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;
    function automatic if_id_t make_slot(input logic [31:0] instr, input logic [31:0] pc);
        return '{instr: instr, pc: pc, pc_plus4: pc + 32'd4, valid: 1'b1};
    endfunction
endpackage

// File: rtl/risc_pipeline_if_id_reg.sv
// risc_pipeline_if_id_reg: IF/ID register with flush, stall and hold/response load mux
module risc_pipeline_if_id_reg
    import risc_pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush_i,
    input  logic   stall_i,
    input  if_id_t hold_i,
    input  if_id_t rsp_i,
    output if_id_t slot_o
);
    if_id_t slot_q, slot_d;
    // flush beats stall; a buffered response drains ahead of a fresh one, else bubble
    always_comb begin
        slot_d = slot_q;
        if (flush_i || (!stall_i && !hold_i.valid && !rsp_i.valid)) begin
            slot_d.instr = NOP_INSTR;
            slot_d.valid = 1'b0;
        end else if (!stall_i) slot_d = hold_i.valid ? hold_i : rsp_i;
    end
    // slot register, empty NOP on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) slot_q <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
        else slot_q <= slot_d;
    end
    assign slot_o = slot_q;
endmodule

// File: rtl/risc_pipeline_fetch.sv
// risc_pipeline_fetch: PC, fetch request FSM, stale-response drop and stall hold buffer
module risc_pipeline_fetch
    import risc_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d, inflight_pc_q, inflight_pc_d;
    if_id_t       hold_q, hold_d, rsp, slot;
    logic         xfer, rsp_valid, flush;

    assign imem_req  = !reset && state_q == S_REQ && !StallF && !hold_q.valid && !PCSrcE;
    assign imem_addr = pcf_q;
    assign xfer      = imem_req && imem_gnt;
    assign rsp_valid = state_q == S_WAIT && imem_rvalid;
    assign flush     = PCSrcE || FlushD;
    assign rsp       = rsp_valid ? make_slot(imem_rdata, inflight_pc_q) : '0;

    // next state: a redirect while waiting turns the pending response into a drop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (xfer) state_d = S_WAIT;
            S_WAIT:  state_d = imem_rvalid ? S_REQ : PCSrcE ? S_DROP : S_WAIT;
            S_DROP:  if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
        pcf_d         = PCSrcE ? PCTargetE : xfer ? pcf_q + 32'd4 : pcf_q;
        inflight_pc_d = xfer ? pcf_q : inflight_pc_q;
        hold_d        = (flush || !StallD) ? '0 : rsp_valid ? rsp : hold_q;
    end

    // fetch state, PC and hold buffer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pcf_q         <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            inflight_pc_q <= inflight_pc_d;
            hold_q        <= hold_d;
        end
    end

    risc_pipeline_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .stall_i (StallD),
        .hold_i  (hold_q),
        .rsp_i   (rsp),
        .slot_o  (slot)
    );

    assign InstrD   = slot.instr;
    assign PCD      = slot.pc;
    assign PCPlus4D = slot.pc_plus4;
    assign ValidD   = slot.valid;
endmodule

// File: tb/tb_risc_pipeline_fetch.sv
// tb_risc_pipeline_fetch: directed fetch scenarios with request and delivery scoreboards
module tb_risc_pipeline_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic reset, StallF, StallD, FlushD, PCSrcE, imem_gnt, imem_rvalid, imem_req, ValidD;
    logic [31:0] PCTargetE, imem_rdata, imem_addr, InstrD, PCD, PCPlus4D;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem [logic [31:0]];
    int passed = 0, total = 0, lat = 1;

    risc_pipeline_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hBAD0_0000 ^ a);
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p4);
        exp_t e;
        e = '{d, a, p4};
        mem[a] = d;
        addr_q.push_back(a);
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p4);
        push(a, d, p4);
        StallF = 0;
        step(1);
        StallF = 1;
        step(2);
    endtask

    // memory: accepts a transfer seen this cycle, answers lat cycles later
    initial begin
        logic pend;
        int cnt;
        logic [31:0] pa;
        pend = 0; cnt = 0; pa = 0;
        imem_rvalid = 0;
        imem_rdata = 0;
        forever begin
            @(negedge clk);
            if (!reset && imem_req && imem_gnt) begin
                pend = 1; cnt = lat; pa = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata = mem_rd(pa);
                    pend = 0;
                end
            end
        end
    end

    // monitor: request addresses and instructions consumed by decode
    always @(negedge clk) begin
        if (!reset && imem_req && imem_gnt) begin
            if (addr_q.size() == 0) begin
                total++;
                $display("FAIL req_addr: got unexpected request at %h expected none", imem_addr);
            end else chk("req_addr", imem_addr, addr_q.pop_front());
        end
        if (!reset && ValidD && !StallD && !FlushD && !PCSrcE) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL deliver: got unexpected InstrD %h PCD %h expected none", InstrD, PCD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("InstrD", InstrD, e.instr);
                chk("PCD", PCD, e.pc);
                chk("PCPlus4D", PCPlus4D, e.pc4);
            end
        end
    end

    initial begin
        reset = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_gnt = 1;
        step(2); look();
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_addr", imem_addr, 32'hFFFF_FFFC);
        chk("rst_valid", {31'd0, ValidD}, 0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 0);
        chk("rst_pc4", PCPlus4D, 0);
        reset = 0; StallF = 1;
        step(1);
        // first fetch wraps the PC
        fetch(32'hFFFF_FFFC, 32'h0000_0513, 32'h0000_0000);
        look(); chk("wrap_addr", imem_addr, 32'h0);
        fetch(32'h0, 32'h0050_0093, 32'h4);
        look(); chk("next_addr", imem_addr, 32'h4);
        // decode stall while the response lands in the hold buffer
        step(1);
        push(32'h4, 32'h0020_8133, 32'h8);
        StallF = 0; step(1);
        StallD = 1; step(1); look();
        chk("hold_req", {31'd0, imem_req}, 0);
        chk("hold_valid", {31'd0, ValidD}, 0);
        chk("hold_instr", InstrD, NOP);
        step(1); look();
        chk("hold_req2", {31'd0, imem_req}, 0);
        StallD = 0;
        push(32'h8, 32'h0031_01b3, 32'hC);
        look();
        chk("drain_req", {31'd0, imem_req}, 0);
        step(1); look();
        chk("drain_valid", {31'd0, ValidD}, 1);
        chk("drain_instr", InstrD, 32'h0020_8133);
        chk("resume_req", {31'd0, imem_req}, 1);
        chk("resume_addr", imem_addr, 32'h8);
        step(1);
        StallF = 1; step(2);
        // redirect while waiting on a slow response
        lat = 3;
        addr_q.push_back(32'hC); mem[32'hC] = 32'hDEAD_BEEF;
        StallF = 0; step(1);
        StallF = 1; PCSrcE = 1; PCTargetE = 32'h100; look();
        chk("redir_req", {31'd0, imem_req}, 0);
        step(1);
        PCSrcE = 0; look();
        chk("drop_valid1", {31'd0, ValidD}, 0);
        step(1); look();
        chk("drop_valid2", {31'd0, ValidD}, 0);
        step(1); look();
        chk("drop_valid3", {31'd0, ValidD}, 0);
        chk("drop_addr", imem_addr, 32'h100);
        lat = 1;
        fetch(32'h100, 32'h00A0_0293, 32'h104);
        // redirect coinciding with the response
        addr_q.push_back(32'h104); mem[32'h104] = 32'h1111_1111;
        StallF = 0; step(1);
        StallF = 1; PCSrcE = 1; PCTargetE = 32'h200; step(1);
        PCSrcE = 0; look();
        chk("coin_valid", {31'd0, ValidD}, 0);
        chk("coin_instr", InstrD, NOP);
        chk("coin_addr", imem_addr, 32'h200);
        fetch(32'h200, 32'h00C0_0313, 32'h204);
        // flush alone empties a full hold buffer
        addr_q.push_back(32'h204); mem[32'h204] = 32'h2222_2222;
        StallF = 0; step(1);
        StallF = 1; StallD = 1; step(1);
        StallD = 0; FlushD = 1; look();
        chk("flush_valid0", {31'd0, ValidD}, 0);
        step(1);
        FlushD = 0; look();
        chk("flush_valid1", {31'd0, ValidD}, 0);
        chk("flush_addr", imem_addr, 32'h208);
        step(1); look();
        chk("flush_valid2", {31'd0, ValidD}, 0);
        // back-to-back fetches, one per two cycles
        push(32'h208, 32'h0040_0393, 32'h20C);
        push(32'h20C, 32'h0050_0413, 32'h210);
        StallF = 0; step(3);
        StallF = 1; step(2);
        // reset while a response is still outstanding
        lat = 2;
        addr_q.push_back(32'h210); mem[32'h210] = 32'h3333_3333;
        StallF = 0; step(1);
        reset = 1; look();
        chk("midrst_req", {31'd0, imem_req}, 0);
        chk("midrst_valid", {31'd0, ValidD}, 0);
        step(1);
        reset = 0; StallF = 1; step(1); look();
        chk("postrst_valid", {31'd0, ValidD}, 0);
        chk("postrst_addr", imem_addr, 32'hFFFF_FFFC);
        lat = 1;
        fetch(32'hFFFF_FFFC, 32'h0000_0593, 32'h0000_0000);
        step(2);
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("addr_q_empty", 32'(addr_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
